// File: rtl/prio_vector_decoder_sync_pkg.sv
// Shared types and constants for the priority-vector decoder.
package prio_vector_decoder_sync_pkg;

   localparam int CODE_W = 3;
   localparam logic [7:0] Y_IDLE = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_QUALIFY = 2'd1,
      ST_HOLD    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

endpackage

// File: rtl/prio_vector_decoder_sync_if.sv
// Encoder-side request bus plus decoded-vector response bus.
interface prio_vector_decoder_sync_if;
   import prio_vector_decoder_sync_pkg::*;

   logic              EN;
   logic              Qc;
   logic              Qb;
   logic              Qa;
   logic              GS;
   logic              ACK;
   logic [7:0]        Y_n;
   logic [CODE_W-1:0] CODE;
   logic              VLD;
   logic              BUSY;

   // Driver of the encoder code, enable and acknowledge
   modport master (
      output EN, Qc, Qb, Qa, GS, ACK,
      input  Y_n, CODE, VLD, BUSY
   );

   // The decoder itself
   modport slave (
      input  EN, Qc, Qb, Qa, GS, ACK,
      output Y_n, CODE, VLD, BUSY
   );

endinterface

// File: rtl/prio_vector_decoder_sync_decoder_3_to_8.sv
// Combinational 74LS138 equivalent: 3-bit code to active-low one-hot.
module decoder_3_to_8
   import prio_vector_decoder_sync_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   input  logic              en,
   output logic [7:0]        y_n
);

   // Disabled decoder drives all lines inactive (high)
   always_comb begin
      y_n = Y_IDLE;
      if (en) y_n = ~(8'b1 << code);
   end

endmodule

// File: rtl/prio_vector_decoder_sync.sv
// Registered receiver for a 74LS148-style encoder: qualifies a stable code,
// drives one active-low line until acknowledged, rearms after GS withdraws.
module prio_vector_decoder_sync
   import prio_vector_decoder_sync_pkg::*;
#(
   parameter int STABLE_CYCLES = 3
) (
   input logic                           clk,
   input logic                           rst,
   prio_vector_decoder_sync_if.slave     bus
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic [CODE_W-1:0] code;
   logic [CODE_W-1:0] in_code;
   logic [7:0]        y_n;
   logic [7:0]        dec_y;
   logic              vld;
   logic              busy;

   // Encoder pins are active-low; work with the true code internally
   assign in_code = ~{bus.Qc, bus.Qb, bus.Qa};

   // Saturating increment: the counter never wraps
   assign cnt_inc = (cnt == CNT_TGT) ? cnt : cnt + CNT_ONE;

   // Decode the incoming code; it equals the latched code on every HOLD entry
   decoder_3_to_8 u_dec (
      .code (in_code),
      .en   (1'b1),
      .y_n  (dec_y)
   );

   // Control FSM with registered outputs; rst, then EN=0, take priority
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         code  <= '0;
         y_n   <= Y_IDLE;
         vld   <= 1'b0;
         busy  <= 1'b0;
      end else if (!bus.EN) begin
         state <= ST_IDLE;
         cnt   <= '0;
         y_n   <= Y_IDLE;
         vld   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!bus.GS) begin
                  code <= in_code;
                  cnt  <= CNT_ONE;
                  busy <= 1'b1;
                  if (STABLE_CYCLES == 1) begin
                     state <= ST_HOLD;
                     y_n   <= dec_y;
                     vld   <= 1'b1;
                  end else begin
                     state <= ST_QUALIFY;
                  end
               end
            end
            ST_QUALIFY: begin
               if (bus.GS) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (in_code != code) begin
                  // Code moved: restart qualification on the new value
                  code <= in_code;
                  cnt  <= CNT_ONE;
               end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == CNT_TGT) begin
                     state <= ST_HOLD;
                     y_n   <= dec_y;
                     vld   <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (bus.ACK) begin
                  state <= ST_RELEASE;
                  y_n   <= Y_IDLE;
                  vld   <= 1'b0;
               end
            end
            ST_RELEASE: begin
               // Wait for the request to drop so it cannot retrigger
               if (bus.GS) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               y_n   <= Y_IDLE;
               vld   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Y_n  = y_n;
   assign bus.CODE = code;
   assign bus.VLD  = vld;
   assign bus.BUSY = busy;

endmodule

// File: tb/tb_prio_vector_decoder_sync.sv
// Scoreboard bench: stimulus pushes expected assertions, monitors pop on VLD rise.
module tb_prio_vector_decoder_sync;

   typedef struct {
      logic [2:0] code;
      logic [7:0] y;
      int         at_edge;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   logic pa = 1'b0;
   logic pb = 1'b0;

   prio_vector_decoder_sync_if ia ();
   prio_vector_decoder_sync_if ib ();

   prio_vector_decoder_sync #(.STABLE_CYCLES(3)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ia)
   );

   prio_vector_decoder_sync #(.STABLE_CYCLES(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ib)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_a(input logic [2:0] i);
      {ia.Qc, ia.Qb, ia.Qa} = ~i;
   endtask

   task automatic push_a(input logic [2:0] i, input int lat);
      exp_t e;
      e.code = i;
      e.y = ~(8'b1 << i);
      e.at_edge = cyc + lat;
      qa.push_back(e);
   endtask

   // Monitor for DUT A: check each new assertion against the scoreboard
   always @(negedge clk) begin
      if (ia.VLD === 1'b1 && pa === 1'b0) begin
         if (qa.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_assert_a y_n=%h code=%0d cyc=%0d", ia.Y_n, ia.CODE, cyc);
         end else begin
            ea = qa.pop_front();
            chk("assert_a_y_n", int'(ia.Y_n), int'(ea.y));
            chk("assert_a_code", int'(ia.CODE), int'(ea.code));
            chk("assert_a_edge", cyc, ea.at_edge);
         end
      end
      pa = ia.VLD;
      if (cyc > 0) begin
         chk("onehot_a", int'($countones(~ia.Y_n) <= 1), 1);
         chk("vld_match_a", int'(ia.VLD), int'(ia.Y_n != 8'hFF));
      end
   end

   // Monitor for DUT B
   always @(negedge clk) begin
      if (ib.VLD === 1'b1 && pb === 1'b0) begin
         if (qb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_assert_b y_n=%h code=%0d cyc=%0d", ib.Y_n, ib.CODE, cyc);
         end else begin
            eb = qb.pop_front();
            chk("assert_b_y_n", int'(ib.Y_n), int'(eb.y));
            chk("assert_b_code", int'(ib.CODE), int'(eb.code));
            chk("assert_b_edge", cyc, eb.at_edge);
         end
      end
      pb = ib.VLD;
   end

   initial begin
      exp_t e;
      rst = 1'b1;
      ia.EN = 1'b1; ia.GS = 1'b0; ia.ACK = 1'b0;
      {ia.Qc, ia.Qb, ia.Qa} = 3'b000;
      ib.EN = 1'b1; ib.GS = 1'b1; ib.ACK = 1'b0;
      {ib.Qc, ib.Qb, ib.Qa} = 3'b111;

      // Reset held two edges with a live request
      step(1);
      chk("rst_y_n", int'(ia.Y_n), 8'hFF);
      chk("rst_vld", int'(ia.VLD), 0);
      chk("rst_busy", int'(ia.BUSY), 0);
      step(1);
      chk("rst2_y_n", int'(ia.Y_n), 8'hFF);
      chk("rst2_code", int'(ia.CODE), 0);
      chk("rst2_busy", int'(ia.BUSY), 0);
      rst = 1'b0;
      push_a(3'd7, 3);
      step(4);
      ia.ACK = 1'b1;
      step(1);
      ia.ACK = 1'b0;
      chk("post_rst_release_y_n", int'(ia.Y_n), 8'hFF);
      ia.GS = 1'b1;
      step(2);

      // Sweep all eight codes
      for (int i = 0; i < 8; i++) begin
         set_a(3'(i));
         ia.GS = 1'b0;
         push_a(3'(i), 3);
         step(4);
         chk("sweep_busy_hold", int'(ia.BUSY), 1);
         ia.ACK = 1'b1;
         step(1);
         ia.ACK = 1'b0;
         chk("sweep_ack_y_n", int'(ia.Y_n), 8'hFF);
         chk("sweep_ack_vld", int'(ia.VLD), 0);
         chk("sweep_ack_busy", int'(ia.BUSY), 1);
         ia.GS = 1'b1;
         step(2);
         chk("sweep_idle_busy", int'(ia.BUSY), 0);
      end

      // Glitch: code changes one edge into qualification
      set_a(3'd2);
      ia.GS = 1'b0;
      step(1);
      set_a(3'd5);
      push_a(3'd5, 3);
      step(2);
      chk("glitch_no_early", int'(ia.Y_n), 8'hFF);
      step(2);
      chk("glitch_y_n", int'(ia.Y_n), 8'hDF);
      chk("glitch_code", int'(ia.CODE), 5);
      ia.ACK = 1'b1;
      step(1);
      ia.ACK = 1'b0;
      ia.GS = 1'b1;
      step(2);

      // GS pulse mid-qualify aborts the request
      set_a(3'd3);
      ia.GS = 1'b0;
      step(1);
      ia.GS = 1'b1;
      step(1);
      chk("gs_abort_y_n", int'(ia.Y_n), 8'hFF);
      chk("gs_abort_busy", int'(ia.BUSY), 0);
      step(2);

      // Hold ignores code/GS churn; ACK with GS low waits for a fresh request
      set_a(3'd4);
      ia.GS = 1'b0;
      push_a(3'd4, 3);
      step(4);
      set_a(3'd1);
      step(1);
      ia.GS = 1'b1;
      step(1);
      ia.GS = 1'b0;
      set_a(3'd6);
      step(1);
      chk("hold_frozen_y_n", int'(ia.Y_n), 8'hEF);
      chk("hold_frozen_code", int'(ia.CODE), 4);
      ia.ACK = 1'b1;
      step(1);
      ia.ACK = 1'b0;
      chk("rel_y_n", int'(ia.Y_n), 8'hFF);
      step(3);
      chk("rel_wait_busy", int'(ia.BUSY), 1);
      chk("rel_wait_y_n", int'(ia.Y_n), 8'hFF);
      ia.GS = 1'b1;
      step(1);
      chk("rearm_idle_busy", int'(ia.BUSY), 0);
      ia.GS = 1'b0;
      push_a(3'd6, 3);
      step(4);

      // EN=0 beats ACK in HOLD
      ia.EN = 1'b0;
      ia.ACK = 1'b1;
      step(1);
      ia.ACK = 1'b0;
      chk("en_pri_y_n", int'(ia.Y_n), 8'hFF);
      chk("en_pri_busy", int'(ia.BUSY), 0);
      chk("en_pri_vld", int'(ia.VLD), 0);
      step(6);
      chk("en_off_busy", int'(ia.BUSY), 0);
      chk("en_off_y_n", int'(ia.Y_n), 8'hFF);
      ia.EN = 1'b1;
      ia.GS = 1'b1;
      step(2);

      // STABLE_CYCLES=1: assert on the first sampling edge
      {ib.Qc, ib.Qb, ib.Qa} = ~3'd3;
      ib.GS = 1'b0;
      e.code = 3'd3;
      e.y = 8'hF7;
      e.at_edge = cyc + 1;
      qb.push_back(e);
      step(1);
      chk("s1_y_n", int'(ib.Y_n), 8'hF7);
      step(1);
      ib.ACK = 1'b1;
      step(1);
      ib.ACK = 1'b0;
      chk("s1_rel_y_n", int'(ib.Y_n), 8'hFF);
      ib.GS = 1'b1;
      step(2);

      // Reset in the middle of HOLD
      set_a(3'd0);
      ia.GS = 1'b0;
      push_a(3'd0, 3);
      step(4);
      chk("pre_rst_vld", int'(ia.VLD), 1);
      rst = 1'b1;
      step(1);
      chk("mid_rst_y_n", int'(ia.Y_n), 8'hFF);
      chk("mid_rst_vld", int'(ia.VLD), 0);
      chk("mid_rst_busy", int'(ia.BUSY), 0);
      chk("mid_rst_code", int'(ia.CODE), 0);
      rst = 1'b0;
      ia.GS = 1'b1;
      step(3);

      chk("pending_a", qa.size(), 0);
      chk("pending_b", qb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
